// File: rtl/draw_pkg.sv
// draw_pkg: constants shared by the draw_* layers (state codes, screen size, transparent pixel).
`default_nettype none

package draw_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REVEAL  = 2'd1;
    localparam logic [1:0] ANIMATE = 2'd2;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam int TRANSPARENT_DEF = 0;

endpackage

`default_nettype wire

// File: rtl/splash_addr_gen.sv
// splash_addr_gen: pipeline stage S1 -- window/reveal compare, registered ROM address and vis.
`default_nettype none

module splash_addr_gen #(
    parameter int ICON_WIDTH  = 240,
    parameter int ICON_HEIGHT = 240,
    parameter int X_OFFSET    = 200,
    parameter int Y_OFFSET    = 120,
    parameter int ADDR_W      = 18,
    parameter int FI_W        = 2,
    parameter int RR_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        i_vert,
    input  logic [9:0]        i_horz,
    input  logic              i_enable,
    input  logic [FI_W-1:0]   i_frame_idx,
    input  logic [RR_W-1:0]   i_reveal_rows,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic              o_vis
);

    localparam logic [ADDR_W-1:0] c_X_LO  = ADDR_W'(X_OFFSET);
    localparam logic [ADDR_W-1:0] c_X_HI  = ADDR_W'(X_OFFSET + ICON_WIDTH);
    localparam logic [ADDR_W-1:0] c_Y_LO  = ADDR_W'(Y_OFFSET);
    localparam logic [ADDR_W-1:0] c_Y_HI  = ADDR_W'(Y_OFFSET + ICON_HEIGHT);
    localparam logic [ADDR_W-1:0] c_W     = ADDR_W'(ICON_WIDTH);
    localparam logic [ADDR_W-1:0] c_FRAME = ADDR_W'(ICON_WIDTH * ICON_HEIGHT);

    logic [ADDR_W-1:0] w_vert;
    logic [ADDR_W-1:0] w_horz;
    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_col;
    logic [ADDR_W-1:0] w_addr;
    logic              w_in_win;
    logic              w_vis;

    assign w_vert   = ADDR_W'(i_vert);
    assign w_horz   = ADDR_W'(i_horz);
    assign w_row    = w_vert - c_Y_LO;
    assign w_col    = w_horz - c_X_LO;
    assign w_in_win = (w_vert >= c_Y_LO) && (w_vert < c_Y_HI) &&
                      (w_horz >= c_X_LO) && (w_horz < c_X_HI);
    assign w_vis    = w_in_win && i_enable && (w_row < ADDR_W'(i_reveal_rows));
    assign w_addr   = ADDR_W'(i_frame_idx) * c_FRAME + w_row * c_W + w_col;

    // Address only moves for visible pixels so the ROM bus stays quiet elsewhere.
    always_ff @(posedge clk) begin
        if (!reset) begin
            o_rom_addr <= '0;
            o_vis      <= 1'b0;
        end else begin
            o_vis <= w_vis;
            if (w_vis) begin
                o_rom_addr <= w_addr;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/draw_splash_anim.sv
// draw_splash_anim: windowed splash with row-by-row reveal then looping frame animation.
// Optional blinking during ANIMATE when SPLASH_BLINK_EN is defined.
`default_nettype none

module draw_splash_anim
    import draw_pkg::*;
#(
    parameter int ICON_WIDTH  = 240,
    parameter int ICON_HEIGHT = 240,
    parameter int X_OFFSET    = 200,
    parameter int Y_OFFSET    = 120,
    parameter int NUM_FRAMES  = 4,
    parameter int FRAME_TICKS = 15,
    parameter int REVEAL_STEP = 8,
    parameter int ADDR_W      = 18,
    parameter int PIX_W       = 8,
    parameter logic [PIX_W-1:0] TRANSPARENT = PIX_W'(TRANSPARENT_DEF),
`ifdef SPLASH_BLINK_EN
    parameter int BLINK_TICKS = 30,
`endif
    localparam int FI_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trigger,
    input  logic              clear,
    input  logic              frame_tick,
    input  logic [9:0]        vert,
    input  logic [9:0]        horz,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic [PIX_W-1:0]  img_out,
    output logic              active,
    output logic [FI_W-1:0]   frame_idx
);

    localparam int RR_W = $clog2(ICON_HEIGHT + 1);
    localparam int TC_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [RR_W-1:0] r_reveal_rows;
    logic [TC_W-1:0] r_tick_cnt;
    logic [FI_W-1:0] r_frame_idx;
    logic [31:0]     w_reveal_sum;
    logic            w_reveal_done;
    logic            w_enable;
    logic            w_vis_s1;
    logic            r_vis_d2;

    assign w_reveal_sum  = 32'(r_reveal_rows) + 32'(REVEAL_STEP);
    assign w_reveal_done = (w_reveal_sum >= 32'(ICON_HEIGHT));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (trigger) w_next = REVEAL;
                REVEAL:  if (frame_tick && w_reveal_done) w_next = ANIMATE;
                ANIMATE: w_next = ANIMATE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        active = (r_state == REVEAL) || (r_state == ANIMATE);
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r_reveal_rows <= '0;
            r_tick_cnt    <= '0;
            r_frame_idx   <= '0;
        end else begin
            case (r_state)
                REVEAL: begin
                    if (frame_tick) begin
                        r_reveal_rows <= w_reveal_done ? RR_W'(ICON_HEIGHT) : RR_W'(w_reveal_sum);
                    end
                end
                ANIMATE: begin
                    if (frame_tick) begin
                        if (r_tick_cnt == TC_W'(FRAME_TICKS - 1)) begin
                            r_tick_cnt  <= '0;
                            r_frame_idx <= (r_frame_idx == FI_W'(NUM_FRAMES - 1)) ? '0 : r_frame_idx + 1'b1;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_reveal_rows <= '0;
                    r_tick_cnt    <= '0;
                    r_frame_idx   <= '0;
                end
            endcase
        end
    end

`ifdef SPLASH_BLINK_EN
    localparam int BC_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic            r_blink_on;
    logic [BC_W-1:0] r_blink_cnt;

    // Held at 1 outside ANIMATE so the first animated frame is always shown.
    always_ff @(posedge clk) begin
        if (!reset || clear || (r_state != ANIMATE)) begin
            r_blink_on  <= 1'b1;
            r_blink_cnt <= '0;
        end else if (frame_tick) begin
            if (r_blink_cnt == BC_W'(BLINK_TICKS - 1)) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_enable = active && ((r_state != ANIMATE) || r_blink_on);
`else
    assign w_enable = active;
`endif

    splash_addr_gen #(
        .ICON_WIDTH  (ICON_WIDTH),
        .ICON_HEIGHT (ICON_HEIGHT),
        .X_OFFSET    (X_OFFSET),
        .Y_OFFSET    (Y_OFFSET),
        .ADDR_W      (ADDR_W),
        .FI_W        (FI_W),
        .RR_W        (RR_W)
    ) u_addr_gen (
        .clk           (clk),
        .reset         (reset),
        .i_vert        (vert),
        .i_horz        (horz),
        .i_enable      (w_enable),
        .i_frame_idx   (r_frame_idx),
        .i_reveal_rows (r_reveal_rows),
        .o_rom_addr    (rom_addr),
        .o_vis         (w_vis_s1)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vis_d2 <= 1'b0;
            img_out  <= TRANSPARENT;
        end else begin
            r_vis_d2 <= w_vis_s1;
            img_out  <= r_vis_d2 ? rom_data : TRANSPARENT;
        end
    end

    assign frame_idx = r_frame_idx;

endmodule

`default_nettype wire

// File: tb/tb_draw_splash_anim.sv
// tb_draw_splash_anim: directed + randomized bench with a tick-count reference model.
`default_nettype none

module tb_draw_splash_anim;

    localparam int W    = 240;
    localparam int H    = 240;
    localparam int XO   = 200;
    localparam int YO   = 120;
    localparam int NF   = 4;
    localparam int FT   = 15;
    localparam int STEP = 8;
    localparam int BT   = 30;
    localparam int AW   = 18;
    localparam int PW   = 8;
    localparam int N0   = (H + STEP - 1) / STEP;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          trigger;
    logic          clear;
    logic          frame_tick;
    logic [9:0]    vert;
    logic [9:0]    horz;
    logic [AW-1:0] rom_addr;
    logic [PW-1:0] rom_data;
    logic [PW-1:0] img_out;
    logic          active;
    logic [1:0]    frame_idx;

    int tests = 0;
    int fails = 0;

    bit m_run;
    int m_n;
    int m_last_addr;
    int pipe [3];

    always #5 clk = ~clk;

    draw_splash_anim dut (
        .clk        (clk),
        .reset      (rst_n),
        .trigger    (trigger),
        .clear      (clear),
        .frame_tick (frame_tick),
        .vert       (vert),
        .horz       (horz),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .img_out    (img_out),
        .active     (active),
        .frame_idx  (frame_idx)
    );

    function automatic logic [7:0] rom_fn(input int a);
        logic [31:0] x;
        x = a;
        return (x[7:0] ^ x[15:8]) | 8'h01;
    endfunction

    always @(posedge clk) rom_data <= rom_fn(int'(rom_addr));

    function automatic bit m_anim();
        return m_run && (m_n * STEP >= H);
    endfunction

    function automatic int m_reveal();
        return (m_n * STEP < H) ? m_n * STEP : H;
    endfunction

    function automatic int m_frame();
        if (!m_anim()) return 0;
        return ((m_n - N0) / FT) % NF;
    endfunction

    function automatic bit m_blink_ok();
`ifdef SPLASH_BLINK_EN
        if (!m_anim()) return 1'b1;
        return (((m_n - N0) / BT) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit t, input bit c, input bit k, input int v, input int h);
        bit vis;
        int row;
        int col;
        int addr;
        int exp_img;
        rst_n = r; trigger = t; clear = c; frame_tick = k;
        vert = 10'(v); horz = 10'(h);
        row  = v - YO;
        col  = h - XO;
        vis  = r && m_run && (v >= YO) && (v < YO + H) && (h >= XO) && (h < XO + W) &&
               (row < m_reveal()) && m_blink_ok();
        addr    = m_frame() * W * H + row * W + col;
        exp_img = vis ? int'(rom_fn(addr)) : 0;
        @(posedge clk);
        if (!r) begin
            m_run = 1'b0; m_n = 0; m_last_addr = 0;
            pipe[0] = 0; pipe[1] = 0; pipe[2] = 0;
        end else begin
            if (vis) m_last_addr = addr;
            pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = exp_img;
            if (c) begin
                m_run = 1'b0; m_n = 0;
            end else if (!m_run) begin
                if (t) begin m_run = 1'b1; m_n = 0; end
            end else if (k) begin
                m_n++;
            end
        end
        #1;
        check("img_out",   32'(img_out),   pipe[2]);
        check("active",    32'(active),    32'(m_run));
        check("frame_idx", 32'(frame_idx), m_frame());
        check("rom_addr",  32'(rom_addr),  m_last_addr);
        @(negedge clk);
    endtask

    function automatic int rv();
        return $urandom_range(110, 370);
    endfunction

    function automatic int rh();
        return $urandom_range(190, 450);
    endfunction

    task automatic idle_rand(input int n);
        for (int i = 0; i < n; i++) cyc(1, m_run && ($urandom_range(0, 3) == 0), 0, 0, rv(), rh());
    endtask

    task automatic tick();
        idle_rand($urandom_range(1, 3));
        cyc(1, m_run && ($urandom_range(0, 3) == 0), 0, 1, rv(), rh());
    endtask

    initial begin
        rst_n = 1'b0; trigger = 1'b0; clear = 1'b0; frame_tick = 1'b0;
        vert = 10'd0; horz = 10'd0;
        m_run = 1'b0; m_n = 0; m_last_addr = 0;
        pipe[0] = 0; pipe[1] = 0; pipe[2] = 0;

        repeat (2) cyc(0, 0, 0, 0, 150, 250);
        repeat (3) cyc(1, 0, 0, 0, 150, 250);

        cyc(1, 1, 0, 0, 150, 250);
        repeat (3) tick();
        cyc(1, 0, 0, 0, 143, 200);
        check("addr_row23", 32'(rom_addr), 32'd5520);
        cyc(1, 0, 0, 0, 144, 200);
        idle_rand(3);

        repeat (N0 - 3) tick();
        idle_rand(2);
        cyc(1, 0, 0, 0, 119, 300);
        cyc(1, 0, 0, 0, 360, 300);
        cyc(1, 0, 0, 0, 200, 199);
        cyc(1, 0, 0, 0, 200, 440);
        cyc(1, 0, 0, 0, 359, 439);
        check("addr_corner", 32'(rom_addr), 32'd57599);
        idle_rand(3);

        repeat (FT) tick();
        cyc(1, 0, 0, 0, 121, 201);
        check("addr_frame1", 32'(rom_addr), 32'd57841);
        check("frame_one", 32'(frame_idx), 32'd1);
        repeat (NF * FT - FT) tick();
        idle_rand(3);
        check("frame_wrap", 32'(frame_idx), 32'd0);

        cyc(1, 1, 1, 0, 200, 300);
        check("clear_active", 32'(active), 32'd0);
        cyc(1, 1, 0, 0, 200, 300);
        cyc(1, 0, 0, 0, 120, 300);
        tick();
        cyc(1, 0, 0, 0, 120, 300);
        idle_rand(3);

        cyc(1, 0, 1, 0, 200, 300);
        cyc(1, 1, 0, 1, 200, 300);
        cyc(1, 0, 0, 0, 120, 300);
        idle_rand(3);

        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 199) != 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 59) == 0,
                $urandom_range(0, 2) == 0,
                rv(), rh());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
